// File: rtl/rob_alloc_ctrl.sv
// ROB tag-space allocation/retirement controller: all-or-nothing multi-slot
// tag grants against registered occupancy, in-order retire, flush/reset clear.
module rob_alloc_ctrl #(
  parameter int ROB_DEPTH  = 16,
  parameter int TAG_WIDTH  = $clog2(ROB_DEPTH),
  parameter int PIPE_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      alloc_stall,
  input  logic [1:0]                alloc_req,
  output logic [1:0]                alloc_gnt,
  output logic [1:0][TAG_WIDTH-1:0] alloc_tags,
  input  logic [1:0]                commit_req,
  output logic [TAG_WIDTH-1:0]      head_tag,
  output logic [TAG_WIDTH:0]        count,
  output logic                      full,
  output logic                      empty,
  output logic                      commit_err
);

  localparam int CW = $clog2(PIPE_WIDTH + 1);
  localparam logic [TAG_WIDTH:0] DEPTH_C = (TAG_WIDTH+1)'(ROB_DEPTH);

  logic [TAG_WIDTH-1:0] r_head;
  logic [TAG_WIDTH-1:0] r_tail;
  logic [TAG_WIDTH:0]   r_count;
  logic                 r_commit_err;

  logic [CW-1:0]        w_n_req;
  logic [CW-1:0]        w_n_gnt;
  logic [CW-1:0]        w_n_com;
  logic [CW-1:0]        w_n_com_eff;
  logic [TAG_WIDTH:0]   w_free;
  logic                 w_alloc_ok;
  logic                 w_com_err;

  always_comb begin
    w_n_req    = CW'(alloc_req[0]) + CW'(alloc_req[1]);
    w_free     = DEPTH_C - r_count;
    // Space is judged on registered count only; same-cycle retires free nothing.
    w_alloc_ok = !alloc_stall && !flush && !rst && (w_free >= (TAG_WIDTH+1)'(w_n_req));
    w_n_gnt    = w_alloc_ok ? w_n_req : '0;

    w_n_com     = CW'(commit_req[0]) + CW'(commit_req[1]);
    w_com_err   = (commit_req == 2'b10) || ((TAG_WIDTH+1)'(w_n_com) > r_count);
    w_n_com_eff = w_com_err ? '0 : w_n_com;
  end

  assign alloc_gnt     = w_alloc_ok ? alloc_req : 2'b00;
  assign alloc_tags[0] = r_tail;
  assign alloc_tags[1] = alloc_req[0] ? r_tail + TAG_WIDTH'(1) : r_tail;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_commit_err <= 1'b0;
    end else begin
      r_tail       <= r_tail + TAG_WIDTH'(w_n_gnt);
      r_head       <= r_head + TAG_WIDTH'(w_n_com_eff);
      r_count      <= r_count + (TAG_WIDTH+1)'(w_n_gnt) - (TAG_WIDTH+1)'(w_n_com_eff);
      r_commit_err <= w_com_err;
    end
  end

  assign head_tag   = r_head;
  assign count      = r_count;
  assign full       = (r_count == DEPTH_C);
  assign empty      = (r_count == '0);
  assign commit_err = r_commit_err;

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Bench for rob_alloc_ctrl: directed boundary steps plus random traffic, all
// checked against an occupancy/pointer reference model kept in plain integers.
module tb_rob_alloc_ctrl;

  localparam int D  = 16;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst, flush, alloc_stall;
  logic [1:0]      alloc_req, commit_req;
  logic [1:0]      alloc_gnt;
  logic [1:0][TW-1:0] alloc_tags;
  logic [TW-1:0]   head_tag;
  logic [TW:0]     count;
  logic            full, empty, commit_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_head = 0, m_tail = 0, m_count = 0;
  bit m_err = 0;

  rob_alloc_ctrl #(.ROB_DEPTH(D), .TAG_WIDTH(TW), .PIPE_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .alloc_stall(alloc_stall),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tags(alloc_tags),
    .commit_req(commit_req), .head_tag(head_tag), .count(count),
    .full(full), .empty(empty), .commit_err(commit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, check everything at negedge, clock, advance model.
  task automatic step(input logic [1:0] req, input logic stall, input logic [1:0] cm,
                      input logic fl, input logic rs);
    int nreq, ncom, ngnt;
    bit ok, err;
    int exp_t0, exp_t1;
    rst = rs; flush = fl; alloc_stall = stall; alloc_req = req; commit_req = cm;
    nreq = $countones(req);
    ok = !stall && !fl && !rs && ((D - m_count) >= nreq);
    exp_t0 = m_tail;
    exp_t1 = req[0] ? (m_tail + 1) % D : m_tail;
    @(negedge clk);
    if (!rs) begin
      chk("head", 32'(head_tag), 32'(m_head));
      chk("count", 32'(count), 32'(m_count));
      chk("full", 32'(full), 32'(m_count == D));
      chk("empty", 32'(empty), 32'(m_count == 0));
      chk("commit_err", 32'(commit_err), 32'(m_err));
      chk("tag0", 32'(alloc_tags[0]), 32'(exp_t0));
      chk("tag1", 32'(alloc_tags[1]), 32'(exp_t1));
    end
    chk("gnt", 32'(alloc_gnt), ok ? 32'(req) : 32'd0);
    @(posedge clk);
    if (rs || fl) begin
      m_head = 0; m_tail = 0; m_count = 0; m_err = 0;
    end else begin
      ngnt = ok ? nreq : 0;
      ncom = $countones(cm);
      err = (cm == 2'b10) || (ncom > m_count);
      if (err) ncom = 0;
      m_tail  = (m_tail + ngnt) % D;
      m_head  = (m_head + ncom) % D;
      m_count = m_count + ngnt - ncom;
      m_err   = err;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; alloc_stall = 1'b0; alloc_req = 2'b00; commit_req = 2'b00;
    // Reset with requests pending: no grants.
    step(2'b11, 0, 2'b00, 0, 1);
    step(2'b11, 0, 2'b00, 0, 1);
    chk("rst_head", 32'(head_tag), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(commit_err), 32'd0);

    // Fill with 8 pair requests, then a 9th is refused.
    for (int i = 0; i < 8; i++) begin
      alloc_req = 2'b11; #1;
      chk("fill_tag0", 32'(alloc_tags[0]), 32'(2 * i));
      chk("fill_tag1", 32'(alloc_tags[1]), 32'(2 * i + 1));
      step(2'b11, 0, 2'b00, 0, 0);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    step(2'b11, 0, 2'b00, 0, 0);

    // Full with a same-cycle commit: still no grant; grant arrives next cycle.
    step(2'b01, 0, 2'b01, 0, 0);
    chk("full_com_count", 32'(count), 32'd15);
    // count=15: pair refused, single granted, then full again.
    step(2'b11, 0, 2'b00, 0, 0);
    alloc_req = 2'b01; #1;
    chk("single_gnt", 32'(alloc_gnt), 32'b01);
    step(2'b01, 0, 2'b00, 0, 0);
    chk("single_full", 32'(full), 32'd1);
    step(2'b10, 0, 2'b00, 0, 0);

    // Drain to 9, then flush with pair request active.
    for (int i = 0; i < 3; i++) step(2'b00, 0, 2'b11, 0, 0);
    step(2'b00, 0, 2'b01, 0, 0);
    chk("pre_flush_count", 32'(count), 32'd9);
    step(2'b11, 0, 2'b11, 1, 0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);

    // Lone slot-1 request at tail=5.
    step(2'b11, 0, 2'b00, 0, 0);
    step(2'b11, 0, 2'b00, 0, 0);
    step(2'b01, 0, 2'b00, 0, 0);
    alloc_req = 2'b10; #1;
    chk("lone_gnt", 32'(alloc_gnt), 32'b10);
    chk("lone_tag1", 32'(alloc_tags[1]), 32'd5);
    step(2'b10, 0, 2'b00, 0, 0);
    chk("lone_tail_count", 32'(count), 32'd6);

    // Reset mid-stream with alloc and commit active.
    step(2'b11, 0, 2'b11, 0, 1);
    chk("rst_mid_count", 32'(count), 32'd0);

    // Wrap: walk head/tail to 14 with count 0.
    for (int i = 0; i < 7; i++) step(2'b11, 0, 2'b00, 0, 0);
    for (int i = 0; i < 7; i++) step(2'b00, 0, 2'b11, 0, 0);
    chk("wrap_head14", 32'(head_tag), 32'd14);
    step(2'b11, 0, 2'b00, 0, 0);
    alloc_req = 2'b11; #1;
    chk("wrap_tag0", 32'(alloc_tags[0]), 32'd0);
    chk("wrap_tag1", 32'(alloc_tags[1]), 32'd1);
    step(2'b11, 0, 2'b00, 0, 0);
    step(2'b00, 0, 2'b11, 0, 0);
    step(2'b00, 0, 2'b11, 0, 0);
    chk("wrap_head2", 32'(head_tag), 32'd2);
    chk("wrap_empty", 32'(empty), 32'd1);

    // Simultaneous alloc+commit at count=4.
    step(2'b11, 0, 2'b00, 0, 0);
    step(2'b11, 0, 2'b00, 0, 0);
    step(2'b11, 0, 2'b11, 0, 0);
    chk("simul_count", 32'(count), 32'd4);
    chk("simul_head", 32'(head_tag), 32'd4);
    // Down to 1, then underflowing and illegal commits.
    step(2'b00, 0, 2'b11, 0, 0);
    step(2'b00, 0, 2'b01, 0, 0);
    step(2'b00, 0, 2'b11, 0, 0);
    chk("under_err", 32'(commit_err), 32'd1);
    chk("under_count", 32'(count), 32'd1);
    step(2'b00, 0, 2'b10, 0, 0);
    chk("illegal_err", 32'(commit_err), 32'd1);
    chk("illegal_count", 32'(count), 32'd1);
    step(2'b00, 0, 2'b00, 0, 0);
    chk("err_clears", 32'(commit_err), 32'd0);
    // Stall suppresses grants.
    step(2'b11, 1, 2'b00, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [1:0] r, c;
      r = 2'($urandom);
      c = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      step(r, $urandom_range(0, 3) == 0, c, $urandom_range(0, 40) == 0,
           $urandom_range(0, 80) == 0);
    end
    step(2'b00, 0, 2'b00, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
